mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Used in the pipelined core build where instruction and data memory are unified.
- Grants at most one requester per cycle.
- Drives the SRAM port.
- Routes the 1-cycle-latency read data back to the requester that owns it.
- Exposes a stall to the fetch side and a saturating conflict counter for performance debug.

Parameters:
ADDR_W, 32, address width of both requesters and the SRAM port
DATA_W, 32, data width
STARVE_MAX, 4, consecutive denied fetch cycles before forced fetch grant (STARVE_GUARD_EN only)
CNT_W, 16, width of conflict counter

Ports:
clk  input  1  clock, all state updates on posedge
resetn  input  1  synchronous active-low reset
i_req  input  1  fetch request (read only)
i_addr  input  ADDR_W  fetch address
i_gnt  output  1  fetch granted this cycle
i_stall  output  1  i_req & ~i_gnt
i_rvalid  output  1  fetch read data valid
i_rdata  output  DATA_W  fetch read data
d_req  input  1  data request
d_we  input  1  data write enable (1 = write, 0 = read)
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  data write data
d_gnt  output  1  data granted this cycle
d_rvalid  output  1  data read data valid
d_rdata  output  DATA_W  data read data
sram_en  output  1  SRAM access enable
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid the cycle after an enabled read
conflict_cnt  output  CNT_W  count of cycles with i_req & d_req both high, saturating

Behaviour:
- Single clock `clk`. Reset is synchronous and active-low on `resetn`; all registers update on posedge `clk`.
- Grant is combinational in the same cycle as the request. Default priority: d_req over i_req. Grants are never asserted without the matching req.
- sram_en = i_gnt | d_gnt.
- SRAM port muxing:
  - When d_gnt: sram_we = d_we, sram_addr = d_addr, sram_wdata = d_wdata.
  - When i_gnt: sram_we = 0, sram_addr = i_addr.
  - Otherwise: sram_we = 0, addr and wdata = 0.
- Owner register `pend`, states NONE / INST / DATA, updated each cycle:
  - INST if i_gnt.
  - DATA if d_gnt & ~d_we.
  - NONE otherwise (includes writes and idle cycles).
- Response, one cycle after grant:
  - i_rvalid = (pend == INST).
  - d_rvalid = (pend == DATA).
  - i_rdata and d_rdata are sram_rdata gated to 0 when the matching rvalid is low.
- Writes complete at grant and produce no rvalid.
- Back-to-back grants are allowed every cycle. A new grant and the previous response coexist in the same cycle. No bubbles are inserted.
- conflict_cnt increments when i_req & d_req are both high. It holds at 2^CNT_W-1.
- Reset (resetn == 0 at posedge):
  - pend = NONE, conflict_cnt = 0, starvation counter = 0.
  - While resetn is low, i_gnt, d_gnt and sram_en are forced to 0.
  - A read pending at reset produces no rvalid after reset.
- Requester contract:
  - A requester holds req/addr stable until granted.
  - Dropping req before grant is legal; no access occurs.
- Simultaneous i_req and d_req, guard not firing: d_gnt = 1, i_gnt = 0, i_stall = 1.

Optional Feature:
STARVE_GUARD_EN:
- Defined:
  - A counter `starve` counts consecutive cycles with i_req & ~i_gnt.
  - When starve == STARVE_MAX, fetch wins over a simultaneous d_req for that cycle: i_gnt = 1, d_gnt = 0.
  - starve clears on i_gnt, on i_req low, or on reset. It never exceeds STARVE_MAX.
- Undefined: strict data priority; the counter is absent.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, SRAM returns 0xDEADBEEF -> i_gnt=1 in cycle 0; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle 1; d_rvalid=0.
- Contention: i_req=d_req=1, d_we=0, d_addr=0x200 for one cycle -> d_gnt=1, i_stall=1, sram_addr=0x200; next cycle d_rvalid=1; conflict_cnt=1.
- Data write: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> sram_we=1 with the same addr and data; no rvalid on either side next cycle.
- Back-to-back: fetch at cycle 0, data read at cycle 1 -> i_rvalid at cycle 1, d_rvalid at cycle 2, no bubble between them.
- Reset mid-read: grant a fetch read, then assert resetn=0 at the next edge -> i_rvalid=0 afterwards; conflict_cnt=0; grants are 0 while resetn is low.
- STARVE_GUARD_EN, STARVE_MAX=4: hold i_req=d_req=1 -> d_gnt for cycles 0-3; i_gnt=1 and d_gnt=0 in cycle 4; d_gnt resumes in cycle 5. Without the macro, d_gnt in every cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Optional fetch anti-starvation guard is enabled with `define STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_stall,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_INST = 2'd1,
        PEND_DATA = 2'd2
    } pend_e;

    pend_e             pend_q, pend_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic              starve_win;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign starve_win = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX > 0);
    assign starve_win        = 1'b0;
`endif

    // Grants are combinational; data wins unless the starvation guard has fired.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (resetn) begin
            if (starve_win && i_req) i_gnt = 1'b1;
            else if (d_req)          d_gnt = 1'b1;
            else if (i_req)          i_gnt = 1'b1;
        end
    end

    assign i_stall = i_req & ~i_gnt;
    assign sram_en = i_gnt | d_gnt;

    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (d_gnt) begin
            sram_we    = d_we;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (i_gnt) begin
            sram_addr  = i_addr;
        end
    end

    // Remember who owns the read data returning next cycle; writes return nothing.
    always_comb begin
        pend_d = PEND_NONE;
        if (i_gnt)              pend_d = PEND_INST;
        else if (d_gnt && !d_we) pend_d = PEND_DATA;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (i_req && d_req && (conflict_q != {CNT_W{1'b1}}))
            conflict_d = conflict_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q     <= PEND_NONE;
            conflict_q <= '0;
        end else begin
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

    assign i_rvalid     = (pend_q == PEND_INST);
    assign d_rvalid     = (pend_q == PEND_DATA);
    assign i_rdata      = i_rvalid ? sram_rdata : '0;
    assign d_rdata      = d_rvalid ? sram_rdata : '0;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle response scoreboard and behavioural SRAM.
// Build with STARVE_GUARD_EN defined to check the fetch anti-starvation behaviour.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int CW   = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          i_gnt, i_stall, i_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata, sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [CW-1:0] conflict_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Synchronous SRAM: read data appears the cycle after an enabled read and then holds.
    always @(posedge clk)
        if (sram_en && !sram_we) sram_rdata <= mem_f(sram_addr);

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          dv;
        logic [DW-1:0] dd;
    } resp_t;

    resp_t         sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] cnt_m = '0;
    bit            cnt_known = 1'b0;
    int            st_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dw);
        logic  eig, edg;
        resp_t r, nr;
        @(negedge clk);
        resetn = rn; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        #1;
        eig = 1'b0; edg = 1'b0;
        if (rn) begin
            if (GUARD && st_m == SMAX && ir) eig = 1'b1;
            else if (dr)                      edg = 1'b1;
            else if (ir)                      eig = 1'b1;
        end
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        chk("i_stall", i_stall, ir & ~eig);
        chk("sram_en", sram_en, eig | edg);
        chk("sram_we", sram_we, edg & dwe);
        chk("sram_addr", sram_addr, edg ? da : (eig ? ia : '0));
        if (!eig) chk("sram_wdata", sram_wdata, edg ? dw : '0);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("i_rvalid", i_rvalid, r.iv);
            chk("i_rdata", i_rdata, r.id);
            chk("d_rvalid", d_rvalid, r.dv);
            chk("d_rdata", d_rdata, r.dd);
        end
        if (cnt_known) chk("conflict_cnt", conflict_cnt, cnt_m);
        nr = '0;
        if (eig) begin
            nr.iv = 1'b1; nr.id = mem_f(ia);
        end else if (edg && !dwe) begin
            nr.dv = 1'b1; nr.dd = mem_f(da);
        end
        sb.push_back(nr);
        // Model state as it will be after the coming edge
        if (!rn) begin
            cnt_m = '0; cnt_known = 1'b1; st_m = 0;
        end else begin
            if (ir && dr && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
            if (!ir || eig)      st_m = 0;
            else if (st_m < SMAX) st_m = st_m + 1;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset, including requests held high while in reset
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
        idle();
        // Fetch only
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
        idle();
        // Contention on a data read
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
        idle();
        // Data write: no response afterwards
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        idle();
        // Back-to-back fetch then data read
        step(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h208, '0);
        idle();
        // Reset while a fetch read is outstanding
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h20C, '0);
        idle();
        // Sustained contention: guard (if built) forces a fetch grant on the fifth cycle
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h400 + 32'(4 * k), '0);
        idle();
        // Drive the conflict counter into saturation
        for (int k = 0; k < 20; k++)
            step(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600 + 32'(4 * k), '0);
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
